// File: rtl/crtc_pkg.sv
// Shared register map, field widths, power-on defaults and timing bundle for the
// 6545-style CRTC register file.
package crtc_pkg;

  localparam int R_H_TOTAL    = 0;
  localparam int R_H_DISP     = 1;
  localparam int R_H_SYNC     = 2;
  localparam int R_SYNC_WIDTH = 3;
  localparam int R_V_TOTAL    = 4;
  localparam int R_V_ADJUST   = 5;
  localparam int R_V_DISP     = 6;
  localparam int R_V_SYNC     = 7;
  localparam int R_MAX_SCAN   = 9;
  localparam int R_START_HI   = 12;
  localparam int R_START_LO   = 13;
  localparam int R_CURSOR_HI  = 14;
  localparam int R_CURSOR_LO  = 15;

  typedef logic [15:0][7:0] crtc_regs_t;

  // Listed from R15 down to R0 so each entry lands at its register index.
  localparam crtc_regs_t DEFAULTS_40 = {
    8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'd7,  8'h00,
    8'd32, 8'd25, 8'd0,  8'd39, 8'h0F, 8'd41, 8'd40, 8'd49
  };

  // The 80-column PET doubles the horizontal rate on the CPU side, so the CRTC
  // itself is programmed with the same power-on values.
  localparam crtc_regs_t DEFAULTS_80 = {
    8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'd7,  8'h00,
    8'd32, 8'd25, 8'd0,  8'd39, 8'h0F, 8'd41, 8'd40, 8'd49
  };

  typedef struct packed {
    logic [7:0]  h_total;
    logic [7:0]  h_disp;
    logic [7:0]  h_sync_start;
    logic [3:0]  h_sync_width;
    logic [3:0]  v_sync_width;
    logic [6:0]  v_total;
    logic [4:0]  v_adjust;
    logic [6:0]  v_disp;
    logic [6:0]  v_sync_start;
    logic [4:0]  v_char_pixel;
    logic [13:0] screen_addr;
    logic [13:0] cursor_addr;
  } crtc_timing_t;

  function automatic logic [7:0] regMask(input logic [3:0] idx);
    case (idx)
      4'd4, 4'd6, 4'd7: return 8'h7F;
      4'd5, 4'd9:       return 8'h1F;
      4'd12, 4'd14:     return 8'h3F;
      default:          return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/crtc_staged_reg.sv
// One timing register as a staged/active pair; the active copy only moves on a
// commit pulse, and a write coinciding with the commit goes straight through.
module crtc_staged_reg #(
  parameter int           W               = 8,
  parameter bit           COMMIT_ON_FRAME = 1'b1,
  parameter logic [W-1:0] RESET_VAL       = '0
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_commit,
  output logic [W-1:0] o_active
);

  logic [W-1:0] r_staged;
  logic [W-1:0] r_active;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_staged <= RESET_VAL;
      r_active <= RESET_VAL;
    end else begin
      if (i_wr_en) r_staged <= i_wr_data;
      if (!COMMIT_ON_FRAME) begin
        if (i_wr_en) r_active <= i_wr_data;
      end else if (i_commit) begin
        r_active <= i_wr_en ? i_wr_data : r_staged;
      end
    end
  end

  assign o_active = r_active;

endmodule

// File: rtl/crtc_reg_file.sv
// 6545-compatible CRTC register file: decodes the CPU address/data register pair
// and presents frame-coherent timing values to the sync generator.
module crtc_reg_file
  import crtc_pkg::*;
#(
  parameter bit COMMIT_ON_FRAME = 1'b1,
  parameter bit COLS_80         = 1'b0
) (
  input  logic        sys_clk_i,
  input  logic        reset_i,
  input  logic        cs_i,
  input  logic        rs_i,
  input  logic        rw_b_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        data_oe_o,
  input  logic        frame_start_i,
  output logic [7:0]  h_char_total_o,
  output logic [7:0]  h_char_displayed_o,
  output logic [7:0]  h_sync_start_o,
  output logic [3:0]  h_sync_width_o,
  output logic [3:0]  v_sync_width_o,
  output logic [7:0]  v_char_total_o,
  output logic [4:0]  v_adjust_o,
  output logic [7:0]  v_char_displayed_o,
  output logic [7:0]  v_sync_start_o,
  output logic [4:0]  v_char_pixel_size_o,
  output logic [13:0] screen_addr_o,
  output logic [13:0] cursor_addr_o
);

  localparam crtc_regs_t DEFAULTS = COLS_80 ? DEFAULTS_80 : DEFAULTS_40;

  logic [4:0]   r_addr;
  logic [5:0]   r_start_hi;
  logic [7:0]   r_start_lo;
  logic [5:0]   r_cursor_hi;
  logic [7:0]   r_cursor_lo;
  logic [7:0]   r_data;
  logic         r_data_oe;

  logic         w_addr_wr;
  logic         w_data_wr;
  logic         w_rd;
  logic [7:0]   w_wr_data;
  logic [7:0]   w_rd_data;
  crtc_timing_t w_timing;
  logic [7:0]   w_sync_width;

  assign w_addr_wr = cs_i & ~rs_i & ~rw_b_i;
  assign w_data_wr = cs_i &  rs_i & ~rw_b_i;
  assign w_rd      = cs_i &  rw_b_i;
  assign w_wr_data = data_i & regMask(r_addr[3:0]);

  crtc_staged_reg #(.W(8), .COMMIT_ON_FRAME(COMMIT_ON_FRAME), .RESET_VAL(DEFAULTS[R_H_TOTAL]))
    u_r0 (.i_clock(sys_clk_i), .i_reset(reset_i), .i_wr_en(w_data_wr && r_addr == 5'(R_H_TOTAL)),
          .i_wr_data(w_wr_data), .i_commit(frame_start_i), .o_active(w_timing.h_total));

  crtc_staged_reg #(.W(8), .COMMIT_ON_FRAME(COMMIT_ON_FRAME), .RESET_VAL(DEFAULTS[R_H_DISP]))
    u_r1 (.i_clock(sys_clk_i), .i_reset(reset_i), .i_wr_en(w_data_wr && r_addr == 5'(R_H_DISP)),
          .i_wr_data(w_wr_data), .i_commit(frame_start_i), .o_active(w_timing.h_disp));

  crtc_staged_reg #(.W(8), .COMMIT_ON_FRAME(COMMIT_ON_FRAME), .RESET_VAL(DEFAULTS[R_H_SYNC]))
    u_r2 (.i_clock(sys_clk_i), .i_reset(reset_i), .i_wr_en(w_data_wr && r_addr == 5'(R_H_SYNC)),
          .i_wr_data(w_wr_data), .i_commit(frame_start_i), .o_active(w_timing.h_sync_start));

  // R3 packs both sync widths; a zero vertical width is passed through untouched.
  crtc_staged_reg #(.W(8), .COMMIT_ON_FRAME(COMMIT_ON_FRAME), .RESET_VAL(DEFAULTS[R_SYNC_WIDTH]))
    u_r3 (.i_clock(sys_clk_i), .i_reset(reset_i), .i_wr_en(w_data_wr && r_addr == 5'(R_SYNC_WIDTH)),
          .i_wr_data(w_wr_data), .i_commit(frame_start_i), .o_active(w_sync_width));

  assign w_timing.h_sync_width = w_sync_width[3:0];
  assign w_timing.v_sync_width = w_sync_width[7:4];

  crtc_staged_reg #(.W(7), .COMMIT_ON_FRAME(COMMIT_ON_FRAME), .RESET_VAL(DEFAULTS[R_V_TOTAL][6:0]))
    u_r4 (.i_clock(sys_clk_i), .i_reset(reset_i), .i_wr_en(w_data_wr && r_addr == 5'(R_V_TOTAL)),
          .i_wr_data(w_wr_data[6:0]), .i_commit(frame_start_i), .o_active(w_timing.v_total));

  crtc_staged_reg #(.W(5), .COMMIT_ON_FRAME(COMMIT_ON_FRAME), .RESET_VAL(DEFAULTS[R_V_ADJUST][4:0]))
    u_r5 (.i_clock(sys_clk_i), .i_reset(reset_i), .i_wr_en(w_data_wr && r_addr == 5'(R_V_ADJUST)),
          .i_wr_data(w_wr_data[4:0]), .i_commit(frame_start_i), .o_active(w_timing.v_adjust));

  crtc_staged_reg #(.W(7), .COMMIT_ON_FRAME(COMMIT_ON_FRAME), .RESET_VAL(DEFAULTS[R_V_DISP][6:0]))
    u_r6 (.i_clock(sys_clk_i), .i_reset(reset_i), .i_wr_en(w_data_wr && r_addr == 5'(R_V_DISP)),
          .i_wr_data(w_wr_data[6:0]), .i_commit(frame_start_i), .o_active(w_timing.v_disp));

  crtc_staged_reg #(.W(7), .COMMIT_ON_FRAME(COMMIT_ON_FRAME), .RESET_VAL(DEFAULTS[R_V_SYNC][6:0]))
    u_r7 (.i_clock(sys_clk_i), .i_reset(reset_i), .i_wr_en(w_data_wr && r_addr == 5'(R_V_SYNC)),
          .i_wr_data(w_wr_data[6:0]), .i_commit(frame_start_i), .o_active(w_timing.v_sync_start));

  crtc_staged_reg #(.W(5), .COMMIT_ON_FRAME(COMMIT_ON_FRAME), .RESET_VAL(DEFAULTS[R_MAX_SCAN][4:0]))
    u_r9 (.i_clock(sys_clk_i), .i_reset(reset_i), .i_wr_en(w_data_wr && r_addr == 5'(R_MAX_SCAN)),
          .i_wr_data(w_wr_data[4:0]), .i_commit(frame_start_i), .o_active(w_timing.v_char_pixel));

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_addr <= '0;
    end else if (w_addr_wr) begin
      r_addr <= data_i[4:0];
    end
  end

  // Start and cursor addresses are not frame-critical, so they bypass staging.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_start_hi  <= DEFAULTS[R_START_HI][5:0];
      r_start_lo  <= DEFAULTS[R_START_LO];
      r_cursor_hi <= DEFAULTS[R_CURSOR_HI][5:0];
      r_cursor_lo <= DEFAULTS[R_CURSOR_LO];
    end else if (w_data_wr) begin
      case (r_addr)
        5'(R_START_HI):  r_start_hi  <= w_wr_data[5:0];
        5'(R_START_LO):  r_start_lo  <= w_wr_data;
        5'(R_CURSOR_HI): r_cursor_hi <= w_wr_data[5:0];
        5'(R_CURSOR_LO): r_cursor_lo <= w_wr_data;
        default: ;
      endcase
    end
  end

  assign w_timing.screen_addr = {r_start_hi, r_start_lo};
  assign w_timing.cursor_addr = {r_cursor_hi, r_cursor_lo};

  always_comb begin
    w_rd_data = 8'h00;
    if (rs_i && r_addr == 5'(R_CURSOR_HI)) w_rd_data = {2'b00, r_cursor_hi};
    else if (rs_i && r_addr == 5'(R_CURSOR_LO)) w_rd_data = r_cursor_lo;
  end

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_data    <= '0;
      r_data_oe <= 1'b0;
    end else begin
      r_data_oe <= w_rd;
      r_data    <= w_rd ? w_rd_data : 8'h00;
    end
  end

  assign data_o              = r_data;
  assign data_oe_o           = r_data_oe;
  assign h_char_total_o      = w_timing.h_total;
  assign h_char_displayed_o  = w_timing.h_disp;
  assign h_sync_start_o      = w_timing.h_sync_start;
  assign h_sync_width_o      = w_timing.h_sync_width;
  assign v_sync_width_o      = w_timing.v_sync_width;
  assign v_char_total_o      = {1'b0, w_timing.v_total};
  assign v_adjust_o          = w_timing.v_adjust;
  assign v_char_displayed_o  = {1'b0, w_timing.v_disp};
  assign v_sync_start_o      = {1'b0, w_timing.v_sync_start};
  assign v_char_pixel_size_o = w_timing.v_char_pixel;
  assign screen_addr_o       = w_timing.screen_addr;
  assign cursor_addr_o       = w_timing.cursor_addr;

endmodule
